// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Hardwired Moore sequencer that issues every datapath strobe
//               for instruction fetch and execute (ld/ldi/st/ALU/imm/br/halt).
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit #(
    parameter int               OP_W   = 5,
    parameter logic [OP_W-1:0]  ADD_OP = 5'b00011
) (
    input  logic            Clock,
    input  logic            clear,
    input  logic [31:0]     IR,
    input  logic            CON_FF,
    input  logic            Stop,
    output logic            PCout,
    output logic            PCin,
    output logic            IncPC,
    output logic            MARin,
    output logic            MDRin,
    output logic            MDRout,
    output logic            Read,
    output logic            Write,
    output logic            IRin,
    output logic            Yin,
    output logic            Zin,
    output logic            Zlowout,
    output logic            Cout,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic            BAout,
    output logic            CONin,
    output logic [OP_W-1:0] opcode,
    output logic            Run
);

    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OP_W-1:0] OP_BR   = 5'b10010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_IDLE = 4'd1,
        S_T0   = 4'd2,
        S_T1   = 4'd3,
        S_T2   = 4'd4,
        S_T3   = 4'd5,
        S_T4   = 4'd6,
        S_T5   = 4'd7,
        S_T6   = 4'd8,
        S_T7   = 4'd9,
        S_HALT = 4'd10
    } state_t;

    state_t          state_q;
    state_t          state_d;
    state_t          entry_st;
    logic [OP_W-1:0] op;
    logic [OP_W-1:0] imm_alu;
    logic            is_ld;
    logic            is_ldi;
    logic            is_st;
    logic            is_mem;
    logic            is_rtype;
    logic            is_imm;
    logic            is_br;
    logic            is_halt;
    logic            unused_ir_bits;

    // Low IR bits hold register fields and constants used only by the datapath.
    assign unused_ir_bits = ^IR[26:0];

    assign op       = IR[31:27];
    assign is_ld    = (op == OP_LD);
    assign is_ldi   = (op == OP_LDI);
    assign is_st    = (op == OP_ST);
    assign is_mem   = is_ld | is_ldi | is_st;
    assign is_rtype = (op == OP_ADD) | (op == OP_SUB) | (op == OP_AND) | (op == OP_OR);
    assign is_imm   = (op == OP_ADDI) | (op == OP_ANDI) | (op == OP_ORI);
    assign is_br    = (op == OP_BR);
    assign is_halt  = (op == OP_HALT);

    always_comb begin
        imm_alu = ADD_OP;
        if (op == OP_ANDI) begin
            imm_alu = OP_AND;
        end else if (op == OP_ORI) begin
            imm_alu = OP_OR;
        end
    end

    // Every T0 entry is gated by Stop so an in-flight instruction always completes.
    assign entry_st = Stop ? S_IDLE : S_T0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:  state_d = entry_st;
            S_IDLE: state_d = entry_st;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_mem | is_rtype | is_imm | is_br) begin
                    state_d = S_T3;
                end else begin
                    state_d = entry_st;
                end
            end
            S_T3:   state_d = S_T4;
            S_T4:   state_d = S_T5;
            S_T5:   state_d = (is_ld | is_st | is_br) ? S_T6 : entry_st;
            S_T6:   state_d = is_br ? entry_st : S_T7;
            S_T7:   state_d = entry_st;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Decoded from the state register: IR is loaded on the same edge that
    // enters T3, so a pre-registered decode would see the previous instruction.
    always_comb begin
        PCout   = 1'b0;
        PCin    = 1'b0;
        IncPC   = 1'b0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        Cout    = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        BAout   = 1'b0;
        CONin   = 1'b0;
        opcode  = '0;
        Run     = (state_q != S_HALT);
        case (state_q)
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; opcode = ADD_OP;
            end
            S_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                if (is_mem) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (is_rtype | is_imm) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_br) begin
                    Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                end
            end
            S_T4: begin
                if (is_mem) begin
                    Cout = 1'b1; Zin = 1'b1; opcode = ADD_OP;
                end else if (is_rtype) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op;
                end else if (is_imm) begin
                    Cout = 1'b1; Zin = 1'b1; opcode = imm_alu;
                end else if (is_br) begin
                    PCout = 1'b1; Yin = 1'b1;
                end
            end
            S_T5: begin
                if (is_ld | is_st) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                end else if (is_ldi | is_rtype | is_imm) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_br) begin
                    Cout = 1'b1; Zin = 1'b1; opcode = ADD_OP;
                end
            end
            S_T6: begin
                if (is_ld) begin
                    Read = 1'b1; MDRin = 1'b1;
                end else if (is_st) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (is_br && CON_FF) begin
                    Zlowout = 1'b1; PCin = 1'b1;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_st) begin
                    Write = 1'b1;
                end
            end
            default: begin
                opcode = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit
// Description : Directed vector bench for control_unit with protocol monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] IR = 32'h0;
    logic        CON_FF = 1'b0;
    logic        Stop = 1'b0;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write;
    logic        IRin, Yin, Zin, Zlowout, Cout, Gra, Grb, Grc, Rin, Rout, BAout, CONin;
    logic [4:0]  opcode;
    logic        Run;

    control_unit dut (
        .Clock(Clock), .clear(clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin),
        .Zin(Zin), .Zlowout(Zlowout), .Cout(Cout), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .BAout(BAout), .CONin(CONin), .opcode(opcode), .Run(Run)
    );

    always #5 Clock = ~Clock;

    localparam logic [25:0] CONIN  = 26'd1 << 0;
    localparam logic [25:0] BAOUT  = 26'd1 << 1;
    localparam logic [25:0] ROUT   = 26'd1 << 2;
    localparam logic [25:0] RIN    = 26'd1 << 3;
    localparam logic [25:0] GRC    = 26'd1 << 4;
    localparam logic [25:0] GRB    = 26'd1 << 5;
    localparam logic [25:0] GRA    = 26'd1 << 6;
    localparam logic [25:0] COUT   = 26'd1 << 7;
    localparam logic [25:0] ZLOW   = 26'd1 << 8;
    localparam logic [25:0] ZIN    = 26'd1 << 9;
    localparam logic [25:0] YIN    = 26'd1 << 10;
    localparam logic [25:0] IRIN   = 26'd1 << 11;
    localparam logic [25:0] WRITE  = 26'd1 << 12;
    localparam logic [25:0] READ   = 26'd1 << 13;
    localparam logic [25:0] MDROUT = 26'd1 << 14;
    localparam logic [25:0] MDRIN  = 26'd1 << 15;
    localparam logic [25:0] MARIN  = 26'd1 << 16;
    localparam logic [25:0] INCPC  = 26'd1 << 17;
    localparam logic [25:0] PCIN   = 26'd1 << 18;
    localparam logic [25:0] PCOUT  = 26'd1 << 19;
    localparam logic [25:0] OPADD  = 26'h3 << 20;
    localparam logic [25:0] OPSUB  = 26'h4 << 20;
    localparam logic [25:0] OPAND  = 26'h5 << 20;
    localparam logic [25:0] OPOR   = 26'h6 << 20;
    localparam logic [25:0] RUN    = 26'd1 << 25;

    localparam logic [25:0] F0   = RUN | PCOUT | MARIN | INCPC | ZIN | OPADD;
    localparam logic [25:0] F1   = RUN | ZLOW | PCIN | READ | MDRIN;
    localparam logic [25:0] F2   = RUN | MDROUT | IRIN;
    localparam logic [25:0] LD3  = RUN | GRB | BAOUT | YIN;
    localparam logic [25:0] LD4  = RUN | COUT | ZIN | OPADD;
    localparam logic [25:0] LD5  = RUN | ZLOW | MARIN;
    localparam logic [25:0] LD6  = RUN | READ | MDRIN;
    localparam logic [25:0] LD7  = RUN | MDROUT | GRA | RIN;
    localparam logic [25:0] WB   = RUN | ZLOW | GRA | RIN;
    localparam logic [25:0] ST6  = RUN | GRA | ROUT | MDRIN;
    localparam logic [25:0] ST7  = RUN | WRITE;
    localparam logic [25:0] R3   = RUN | GRB | ROUT | YIN;
    localparam logic [25:0] R4   = RUN | GRC | ROUT | ZIN;
    localparam logic [25:0] I4   = RUN | COUT | ZIN;
    localparam logic [25:0] BR3  = RUN | GRA | ROUT | CONIN;
    localparam logic [25:0] BR4  = RUN | PCOUT | YIN;
    localparam logic [25:0] BR5  = RUN | COUT | ZIN | OPADD;
    localparam logic [25:0] BR6T = RUN | ZLOW | PCIN;

    localparam logic [31:0] IR_LD   = 32'h0100_005F;
    localparam logic [31:0] IR_LDI  = 32'h0900_0004;
    localparam logic [31:0] IR_ST   = 32'h1080_0063;
    localparam logic [31:0] IR_ADD  = 32'h1912_0000;
    localparam logic [31:0] IR_SUB  = 32'h2112_0000;
    localparam logic [31:0] IR_AND  = 32'h2912_0000;
    localparam logic [31:0] IR_OR   = 32'h3112_0000;
    localparam logic [31:0] IR_ADDI = 32'h6110_0007;
    localparam logic [31:0] IR_ANDI = 32'h6910_0007;
    localparam logic [31:0] IR_ORI  = 32'h7110_0007;
    localparam logic [31:0] IR_BR   = 32'h9080_0010;
    localparam logic [31:0] IR_HALT = 32'hD800_0000;
    localparam logic [31:0] IR_NOP  = 32'h3800_0000;

    typedef struct packed {
        logic [31:0]      ir;
        logic             con;
        logic [3:0]       len;
        logic [4:0][25:0] ex;
    } vec_t;

    localparam int NV = 13;
    vec_t tbl [NV];

    int total = 0;
    int bad   = 0;

    wire [25:0] bundle = {Run, opcode, PCout, PCin, IncPC, MARin, MDRin, MDRout,
                          Read, Write, IRin, Yin, Zin, Zlowout, Cout, Gra, Grb, Grc,
                          Rin, Rout, BAout, CONin};

    function automatic vec_t mkv(input logic [31:0] ir, input logic con, input logic [3:0] len,
                                 input logic [25:0] e3, input logic [25:0] e4,
                                 input logic [25:0] e5, input logic [25:0] e6,
                                 input logic [25:0] e7);
        vec_t v;
        v.ir  = ir;
        v.con = con;
        v.len = len;
        v.ex  = {e7, e6, e5, e4, e3};
        return v;
    endfunction

    task automatic check(input string nm, input logic [25:0] got, input logic [25:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clock);
        clear = 1'b0;
        #1 check("reset", bundle, RUN);
        @(negedge Clock);
        clear = 1'b1;
    endtask

    task automatic step_check(input string nm, input logic [25:0] exp);
        @(posedge Clock);
        #1 check(nm, bundle, exp);
    endtask

    function automatic logic [25:0] fetch_exp(input int c);
        return (c == 0) ? F0 : ((c == 1) ? F1 : F2);
    endfunction

    // Invariants hold in every state, so check them every cycle outside reset.
    always @(posedge Clock) begin
        #3;
        if (clear) begin
            total++;
            if (Read && Write) begin
                bad++;
                $display("FAIL mon_rw: got Read=%b Write=%b exp not both 1", Read, Write);
            end
            total++;
            if ($countones({PCout, MDRout, Zlowout, Rout, BAout, Cout}) > 1) begin
                bad++;
                $display("FAIL mon_bus: got drivers=%b exp at most one",
                         {PCout, MDRout, Zlowout, Rout, BAout, Cout});
            end
            total++;
            if (opcode != 5'd0 && !Zin) begin
                bad++;
                $display("FAIL mon_op: got opcode=%b with Zin=0 exp opcode=0", opcode);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mkv(IR_LD,   1'b0, 4'd8, LD3, LD4, LD5, LD6, LD7);
        tbl[1]  = mkv(IR_LDI,  1'b0, 4'd6, LD3, LD4, WB,  0,   0);
        tbl[2]  = mkv(IR_ST,   1'b0, 4'd8, LD3, LD4, LD5, ST6, ST7);
        tbl[3]  = mkv(IR_ADD,  1'b0, 4'd6, R3,  R4 | OPADD, WB, 0, 0);
        tbl[4]  = mkv(IR_SUB,  1'b0, 4'd6, R3,  R4 | OPSUB, WB, 0, 0);
        tbl[5]  = mkv(IR_AND,  1'b0, 4'd6, R3,  R4 | OPAND, WB, 0, 0);
        tbl[6]  = mkv(IR_OR,   1'b0, 4'd6, R3,  R4 | OPOR,  WB, 0, 0);
        tbl[7]  = mkv(IR_ADDI, 1'b0, 4'd6, R3,  I4 | OPADD, WB, 0, 0);
        tbl[8]  = mkv(IR_ANDI, 1'b0, 4'd6, R3,  I4 | OPAND, WB, 0, 0);
        tbl[9]  = mkv(IR_ORI,  1'b0, 4'd6, R3,  I4 | OPOR,  WB, 0, 0);
        tbl[10] = mkv(IR_BR,   1'b1, 4'd7, BR3, BR4, BR5, BR6T, 0);
        tbl[11] = mkv(IR_BR,   1'b0, 4'd7, BR3, BR4, BR5, RUN,  0);
        tbl[12] = mkv(IR_NOP,  1'b0, 4'd3, 0,   0,   0,   0,    0);

        // One instruction per vector; the check at c==len proves return to T0.
        for (int v = 0; v < NV; v++) begin
            IR     = tbl[v].ir;
            CON_FF = tbl[v].con;
            Stop   = 1'b0;
            do_reset();
            for (int c = 0; c <= int'(tbl[v].len); c++) begin
                logic [25:0] e;
                if (c == int'(tbl[v].len))
                    e = F0;
                else if (c < 3)
                    e = fetch_exp(c);
                else
                    e = tbl[v].ex[c-3];
                step_check($sformatf("vec%0d_t%0d", v, c), e);
            end
        end

        // halt: Run drops after T2 and Stop has no effect while halted.
        IR = IR_HALT; CON_FF = 1'b0; Stop = 1'b0;
        do_reset();
        step_check("halt_t0", F0);
        step_check("halt_t1", F1);
        step_check("halt_t2", F2);
        for (int i = 0; i < 20; i++) begin
            step_check($sformatf("halted%0d", i), 26'd0);
            if (i == 5) Stop = 1'b1;
            if (i == 10) Stop = 1'b0;
        end

        // Stop high at T0 entry out of reset holds idle; release resumes fetch.
        Stop = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) step_check($sformatf("idle%0d", i), RUN);
        @(negedge Clock);
        Stop = 1'b0;
        step_check("resume_t0", F0);
        step_check("resume_t1", F1);

        // Stop raised mid-instruction: the nop completes, then idles.
        IR = IR_NOP; Stop = 1'b0;
        do_reset();
        step_check("stopnop_t0", F0);
        step_check("stopnop_t1", F1);
        step_check("stopnop_t2", F2);
        Stop = 1'b1;
        step_check("stopnop_idle0", RUN);
        step_check("stopnop_idle1", RUN);
        Stop = 1'b0;
        step_check("stopnop_t0b", F0);

        // clear during ld T5: strobes drop before the next edge, restart at T0.
        IR = IR_LD; CON_FF = 1'b0; Stop = 1'b0;
        do_reset();
        for (int c = 0; c < 6; c++)
            step_check($sformatf("clrld_t%0d", c), (c < 3) ? fetch_exp(c) : tbl[0].ex[c-3]);
        #1 clear = 1'b0;
        #1 check("clr_async", bundle, RUN);
        @(negedge Clock);
        clear = 1'b1;
        step_check("clr_t0", F0);
        step_check("clr_t1", F1);

        @(negedge Clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
